// File: rtl/uart_fetch_ctrl.sv
// uart_fetch_ctrl: fetches one instruction over a byte-wide UART link.
//   Sends FLAG_BYTE, then ADDR_BYTES address bytes (MSB first), then collects
//   DATA_BYTES reply bytes (first byte lands in the MSB) into instruction_out.
// Latency: done pulses the cycle after the final rx_do; IDLE again one cycle later.
// Backpressure: each TX byte is held (tx_start=1) until the UART returns tx_done;
//   RECV waits for rx_do pulses; abort returns to IDLE on the next edge.
// Ports: clk/reset (async, active-high); start/address/abort request side;
//   tx_start/tx_data/tx_done UART TX handshake; rx_do/rx_data UART RX strobe;
//   instruction_out/busy/done/error status.
// Optional: define FETCH_TIMEOUT_EN to abandon RECV after TIMEOUT_CYCLES idle
//   cycles with a one-cycle error pulse.
module uart_fetch_ctrl #(
   parameter int          ADDR_BYTES     = 1,
   parameter int          DATA_BYTES     = 2,
   parameter logic [7:0]  FLAG_BYTE      = 8'h03,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [8*ADDR_BYTES-1:0] address,
   input  logic                    abort,
   input  logic                    tx_done,
   input  logic                    rx_do,
   input  logic [7:0]              rx_data,
   output logic                    tx_start,
   output logic [7:0]              tx_data,
   output logic [8*DATA_BYTES-1:0] instruction_out,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int AW    = 8 * ADDR_BYTES;
   localparam int DW    = 8 * DATA_BYTES;
   localparam int MAXB  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int CNT_W = $clog2(MAXB + 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SEND_FLAG = 3'd1;
   localparam logic [2:0] SEND_ADDR = 3'd2;
   localparam logic [2:0] RECV      = 3'd3;
   localparam logic [2:0] DONE      = 3'd4;
   localparam logic [2:0] ERR       = 3'd5;

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [AW-1:0]    addr_q,  addr_d;
   logic [DW-1:0]    shift_q, shift_d;
   logic [DW-1:0]    instr_q, instr_d;
   logic             timeout_hit;

   // Shift register with the new byte appended in the low position; the
   // upper byte falls off, so the first received byte ends in the MSB.
   logic [DW+7:0]    shift_cat;
   assign shift_cat = {shift_q, rx_data};

`ifdef FETCH_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] idle_q, idle_d;

   // Held at zero outside RECV, so it is already clear on RECV entry.
   always_comb begin
      idle_d = idle_q;
      if (state_q != RECV || rx_do)
         idle_d = 16'd0;
      else
         idle_d = idle_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) idle_q <= 16'd0;
      else       idle_q <= idle_d;
   end

   assign timeout_hit = (idle_q == TIMEOUT_LAST);
   assign error       = (state_q == ERR);
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      shift_d = shift_q;
      instr_d = instr_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               addr_d  = address;
               cnt_d   = '0;
               state_d = SEND_FLAG;
            end
         end
         SEND_FLAG: begin
            if (tx_done) state_d = SEND_ADDR;
         end
         SEND_ADDR: begin
            if (tx_done) begin
               if (cnt_q == ADDR_LAST) begin
                  cnt_d   = '0;
                  state_d = RECV;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         RECV: begin
            if (rx_do) begin
               shift_d = shift_cat[DW-1:0];
               if (cnt_q == DATA_LAST) begin
                  // Load on the edge into DONE so instruction_out is valid
                  // in the same cycle as the done pulse.
                  instr_d = shift_cat[DW-1:0];
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (timeout_hit) begin
               state_d = ERR;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Cancel overrides every event in the same cycle, including the final
      // rx_do, so the result register is left untouched.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         shift_d = shift_q;
         instr_d = instr_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         shift_q <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         shift_q <= shift_d;
         instr_q <= instr_d;
      end
   end

   // TX byte select: address byte ADDR_BYTES-1-cnt, i.e. MSB first.
   always_comb begin
      tx_start = 1'b0;
      tx_data  = 8'h00;
      case (state_q)
         SEND_FLAG: begin
            tx_start = 1'b1;
            tx_data  = FLAG_BYTE;
         end
         SEND_ADDR: begin
            tx_start = 1'b1;
            for (int i = 0; i < ADDR_BYTES; i++) begin
               if (cnt_q == CNT_W'(ADDR_BYTES - 1 - i))
                  tx_data = addr_q[i*8 +: 8];
            end
         end
         default: begin
            tx_start = 1'b0;
            tx_data  = 8'h00;
         end
      endcase
   end

   assign instruction_out = instr_q;
   assign busy            = (state_q != IDLE);
   assign done            = (state_q == DONE);

endmodule

// File: tb/tb_uart_fetch_ctrl.sv
module tb_uart_fetch_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // Default-parameter instance
   logic        start_a, abort_a, tx_done_a, rx_do_a;
   logic [7:0]  address_a, rx_data_a;
   logic        tx_start_a, busy_a, done_a, error_a;
   logic [7:0]  tx_data_a;
   logic [15:0] instr_a;

   // Wide instance: 2 address bytes, 4 data bytes
   logic        start_b, abort_b, tx_done_b, rx_do_b;
   logic [15:0] address_b;
   logic [7:0]  rx_data_b;
   logic        tx_start_b, busy_b, done_b, error_b;
   logic [7:0]  tx_data_b;
   logic [31:0] instr_b;

   uart_fetch_ctrl dut_a (
      .clk(clk), .reset(reset), .start(start_a), .address(address_a),
      .abort(abort_a), .tx_done(tx_done_a), .rx_do(rx_do_a), .rx_data(rx_data_a),
      .tx_start(tx_start_a), .tx_data(tx_data_a), .instruction_out(instr_a),
      .busy(busy_a), .done(done_a), .error(error_a)
   );

   uart_fetch_ctrl #(.ADDR_BYTES(2), .DATA_BYTES(4)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .address(address_b),
      .abort(abort_b), .tx_done(tx_done_b), .rx_do(rx_do_b), .rx_data(rx_data_b),
      .tx_start(tx_start_b), .tx_data(tx_data_b), .instruction_out(instr_b),
      .busy(busy_b), .done(done_b), .error(error_b)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_instr[$];
   logic [15:0] last_instr_a = 16'h0000;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic serve_tx_a;
      int n;
      logic [7:0] e;
      n = 0;
      while (!tx_start_a && n < 20) begin
         step;
         n++;
      end
      e = exp_tx.pop_front();
      checks++;
      if (tx_start_a !== 1'b1 || tx_data_a !== e) begin
         errors++;
         $display("FAIL tx_byte_a: tx_start=%b tx_data=%h, expected tx_start=1 tx_data=%h",
                  tx_start_a, tx_data_a, e);
      end
      tx_done_a = 1'b1;
      step;
      tx_done_a = 1'b0;
   endtask

   task automatic serve_tx_b;
      int n;
      logic [7:0] e;
      n = 0;
      while (!tx_start_b && n < 20) begin
         step;
         n++;
      end
      e = exp_tx.pop_front();
      checks++;
      if (tx_start_b !== 1'b1 || tx_data_b !== e) begin
         errors++;
         $display("FAIL tx_byte_b: tx_start=%b tx_data=%h, expected tx_start=1 tx_data=%h",
                  tx_start_b, tx_data_b, e);
      end
      tx_done_b = 1'b1;
      step;
      tx_done_b = 1'b0;
   endtask

   task automatic rx_a(input logic [7:0] b);
      rx_data_a = b;
      rx_do_a   = 1'b1;
      step;
      rx_do_a   = 1'b0;
   endtask

   // Called right after the final rx byte: DUT should be in its done cycle.
   task automatic finish_a;
      logic [31:0] e;
      e = exp_instr.pop_front();
      checks++;
      if (done_a !== 1'b1 || instr_a !== e[15:0]) begin
         errors++;
         $display("FAIL done_a: done=%b instr=%h, expected done=1 instr=%h", done_a, instr_a, e[15:0]);
      end
      last_instr_a = e[15:0];
      step;
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || instr_a !== e[15:0]) begin
         errors++;
         $display("FAIL after_done_a: done=%b busy=%b instr=%h, expected 0 0 %h",
                  done_a, busy_a, instr_a, e[15:0]);
      end
   endtask

   task automatic fetch_a(input logic [7:0] addr, input logic [7:0] r0, input logic [7:0] r1);
      exp_tx.push_back(8'h03);
      exp_tx.push_back(addr);
      exp_instr.push_back({16'h0000, r0, r1});
      start_a   = 1'b1;
      address_a = addr;
      step;
      start_a   = 1'b0;
      serve_tx_a;
      serve_tx_a;
      checks++;
      if (tx_start_a !== 1'b0 || tx_data_a !== 8'h00 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL recv_idle_tx: tx_start=%b tx_data=%h busy=%b, expected 0 00 1",
                  tx_start_a, tx_data_a, busy_a);
      end
      rx_a(r0);
      rx_a(r1);
      finish_a;
   endtask

   task automatic test_reset;
      checks++;
      if ({tx_start_a, tx_data_a, instr_a, busy_a, done_a, error_a} !== 28'h0) begin
         errors++;
         $display("FAIL reset_a: tx_start=%b tx_data=%h instr=%h busy=%b done=%b error=%b, expected all 0",
                  tx_start_a, tx_data_a, instr_a, busy_a, done_a, error_a);
      end
      checks++;
      if ({tx_start_b, tx_data_b, instr_b, busy_b, done_b, error_b} !== 44'h0) begin
         errors++;
         $display("FAIL reset_b: tx_start=%b tx_data=%h instr=%h busy=%b, expected all 0",
                  tx_start_b, tx_data_b, instr_b, busy_b);
      end
   endtask

   task automatic test_basic;
      fetch_a(8'h5A, 8'h12, 8'h34);
   endtask

   task automatic test_abort;
      exp_tx.push_back(8'h03);
      exp_tx.push_back(8'h77);
      start_a   = 1'b1;
      address_a = 8'h77;
      step;
      start_a   = 1'b0;
      serve_tx_a;
      serve_tx_a;
      rx_a(8'hAA);
      // Abort together with what would be the final rx byte
      abort_a   = 1'b1;
      rx_data_a = 8'hBB;
      rx_do_a   = 1'b1;
      step;
      abort_a   = 1'b0;
      rx_do_a   = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || instr_a !== 16'h1234) begin
         errors++;
         $display("FAIL abort: busy=%b done=%b instr=%h, expected 0 0 1234", busy_a, done_a, instr_a);
      end
      // Abort also blocks a start presented in IDLE
      start_a = 1'b1;
      abort_a = 1'b1;
      step;
      start_a = 1'b0;
      abort_a = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || tx_start_a !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL abort_vs_start: busy=%b tx_start=%b done=%b, expected 0 0 0",
                  busy_a, tx_start_a, done_a);
      end
   endtask

   task automatic test_ignored_events;
      exp_tx.push_back(8'h03);
      exp_tx.push_back(8'h10);
      exp_instr.push_back(32'h0000_0001);
      start_a   = 1'b1;
      address_a = 8'h10;
      step;
      start_a   = 1'b0;
      serve_tx_a;
      rx_a(8'hFF);
      checks++;
      if (tx_start_a !== 1'b1 || tx_data_a !== 8'h10) begin
         errors++;
         $display("FAIL rx_in_send_addr: tx_start=%b tx_data=%h, expected 1 10", tx_start_a, tx_data_a);
      end
      serve_tx_a;
      // tx_done in RECV and start while busy must both be ignored
      tx_done_a = 1'b1;
      step;
      tx_done_a = 1'b0;
      start_a   = 1'b1;
      address_a = 8'h99;
      step;
      start_a   = 1'b0;
      checks++;
      if (busy_a !== 1'b1 || tx_start_a !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignores: busy=%b tx_start=%b done=%b, expected 1 0 0",
                  busy_a, tx_start_a, done_a);
      end
      rx_a(8'h00);
      rx_a(8'h01);
      finish_a;
   endtask

   task automatic test_back_to_back;
      fetch_a(8'hC3, 8'hAB, 8'hCD);
      fetch_a(8'h01, 8'h9E, 8'h5F);
   endtask

   task automatic test_timeout;
      int n;
      exp_tx.push_back(8'h03);
      exp_tx.push_back(8'h66);
      start_a   = 1'b1;
      address_a = 8'h66;
      step;
      start_a   = 1'b0;
      serve_tx_a;
      serve_tx_a;
`ifdef FETCH_TIMEOUT_EN
      n = 0;
      while (!error_a && n < 1100) begin
         step;
         n++;
      end
      checks++;
      if (error_a !== 1'b1 || n != 1024) begin
         errors++;
         $display("FAIL timeout_cycle: error=%b after %0d cycles, expected error=1 after 1024", error_a, n);
      end
      step;
      checks++;
      if (error_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || instr_a !== last_instr_a) begin
         errors++;
         $display("FAIL timeout_after: error=%b busy=%b done=%b instr=%h, expected 0 0 0 %h",
                  error_a, busy_a, done_a, instr_a, last_instr_a);
      end
`else
      n = 0;
      repeat (1100) begin
         step;
         if (error_a !== 1'b0) n++;
      end
      checks++;
      if (n != 0 || busy_a !== 1'b1 || tx_start_a !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout: error cycles=%0d busy=%b tx_start=%b done=%b, expected 0 1 0 0",
                  n, busy_a, tx_start_a, done_a);
      end
      abort_a = 1'b1;
      step;
      abort_a = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || instr_a !== last_instr_a) begin
         errors++;
         $display("FAIL no_timeout_abort: busy=%b instr=%h, expected 0 %h", busy_a, instr_a, last_instr_a);
      end
`endif
   endtask

   task automatic test_async_reset;
      start_a   = 1'b1;
      address_a = 8'h5A;
      step;
      start_a   = 1'b0;
      checks++;
      if (tx_start_a !== 1'b1 || tx_data_a !== 8'h03) begin
         errors++;
         $display("FAIL send_flag: tx_start=%b tx_data=%h, expected 1 03", tx_start_a, tx_data_a);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({tx_start_a, tx_data_a, instr_a, busy_a, done_a, error_a} !== 28'h0) begin
         errors++;
         $display("FAIL async_reset: tx_start=%b tx_data=%h instr=%h busy=%b done=%b error=%b, expected all 0",
                  tx_start_a, tx_data_a, instr_a, busy_a, done_a, error_a);
      end
      #1 reset = 1'b0;
      step;
      checks++;
      if (busy_a !== 1'b0 || tx_start_a !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: busy=%b tx_start=%b, expected 0 0", busy_a, tx_start_a);
      end
      fetch_a(8'h5A, 8'h12, 8'h34);
   endtask

   task automatic test_wide;
      logic [7:0]  rxb [4];
      logic [31:0] e;
      rxb[0] = 8'hDE; rxb[1] = 8'hAD; rxb[2] = 8'hC0; rxb[3] = 8'hDE;
      exp_tx.push_back(8'h03);
      exp_tx.push_back(8'hBE);
      exp_tx.push_back(8'hEF);
      exp_instr.push_back(32'hDEADC0DE);
      start_b   = 1'b1;
      address_b = 16'hBEEF;
      step;
      start_b   = 1'b0;
      for (int i = 0; i < 3; i++) serve_tx_b;
      for (int i = 0; i < 4; i++) begin
         rx_data_b = rxb[i];
         rx_do_b   = 1'b1;
         step;
         rx_do_b   = 1'b0;
      end
      e = exp_instr.pop_front();
      checks++;
      if (done_b !== 1'b1 || instr_b !== e) begin
         errors++;
         $display("FAIL wide_done: done=%b instr=%h, expected 1 %h", done_b, instr_b, e);
      end
      step;
      checks++;
      if (done_b !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL wide_idle: done=%b busy=%b, expected 0 0", done_b, busy_b);
      end
   endtask

   initial begin
      reset     = 1'b1;
      start_a   = 1'b0; abort_a = 1'b0; tx_done_a = 1'b0; rx_do_a = 1'b0;
      address_a = 8'h00; rx_data_a = 8'h00;
      start_b   = 1'b0; abort_b = 1'b0; tx_done_b = 1'b0; rx_do_b = 1'b0;
      address_b = 16'h0000; rx_data_b = 8'h00;
      step;
      step;
      test_reset;
      reset = 1'b0;
      step;
      test_basic;
      test_abort;
      test_ignored_events;
      test_back_to_back;
      test_timeout;
      test_async_reset;
      test_wide;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
